// File: rtl/apb3_slave_router_if.sv
// Bus bundle for the APB3 router: upstream master-facing signals and the
// shared downstream slave-facing signals.
interface apb3_slave_router_if #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]            PADDR;
  logic                             PSEL;
  logic                             PENABLE;
  logic                             PWRITE;
  logic [DATA_WIDTH-1:0]            PWDATA;
  logic                             PREADY;
  logic [DATA_WIDTH-1:0]            PRDATA;
  logic                             PSLVERROR;

  logic [ADDR_WIDTH-1:0]            s_PADDR;
  logic                             s_PWRITE;
  logic [DATA_WIDTH-1:0]            s_PWDATA;
  logic                             s_PENABLE;
  logic [NUM_SLAVES-1:0]            s_PSEL;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_PRDATA;
  logic [NUM_SLAVES-1:0]            s_PREADY;
  logic [NUM_SLAVES-1:0]            s_PSLVERROR;

  // Router view: completer toward the upstream master, requester toward slaves.
  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PREADY, PRDATA, PSLVERROR,
    output s_PADDR, s_PWRITE, s_PWDATA, s_PENABLE, s_PSEL,
    input  s_PRDATA, s_PREADY, s_PSLVERROR
  );

  // Environment view: upstream master plus the downstream slave population.
  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PREADY, PRDATA, PSLVERROR,
    input  s_PADDR, s_PWRITE, s_PWDATA, s_PENABLE, s_PSEL,
    output s_PRDATA, s_PREADY, s_PSLVERROR
  );
endinterface

// File: rtl/apb3_slave_router.sv
// Registered one-master-to-NUM_SLAVES APB3 bridge with address-field decode,
// per-access timeout, PSLVERROR on unmapped/timed-out accesses and error logging.
module apb3_slave_router #(
  parameter int NUM_SLAVES     = 4,
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int SEL_LSB        = 12,
  parameter int SEL_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rstn,
  apb3_slave_router_if.slave    bus,
  input  logic                  err_clr,
  output logic [15:0]           err_count,
  output logic [ADDR_WIDTH-1:0] last_err_addr
);

  localparam int TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e                  r_state;
  state_e                  w_next;

  logic [ADDR_WIDTH-1:0]   r_paddr;
  logic                    r_pwrite;
  logic [DATA_WIDTH-1:0]   r_pwdata;
  logic [NUM_SLAVES-1:0]   r_sel;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_err;
  logic [TCNT_W-1:0]       r_tcnt;
  logic [15:0]             r_err_count;
  logic [ADDR_WIDTH-1:0]   r_last_err;

  logic [SEL_WIDTH-1:0]    w_idx;
  logic                    w_mapped;
  logic [NUM_SLAVES-1:0]   w_dec;
  logic                    w_pready;
  logic                    w_start;
  logic                    w_sel_ready;
  logic                    w_sel_err;
  logic                    w_timeout;
  logic [DATA_WIDTH-1:0]   w_slv_rdata;
  logic [NUM_SLAVES-1:0]   w_psel;
  logic                    w_penable;
  logic                    w_log_err;

  assign w_idx    = bus.PADDR[SEL_LSB +: SEL_WIDTH];
  assign w_mapped = (int'(w_idx) < NUM_SLAVES);
  assign w_pready = (r_state == S_RESP);
  // The master still holds PENABLE during our response cycle; never re-trigger on it.
  assign w_start  = bus.PSEL & bus.PENABLE & ~w_pready;

  assign w_sel_ready = |(bus.s_PREADY & r_sel);
  assign w_sel_err   = |(bus.s_PSLVERROR & r_sel);
  assign w_timeout   = (TIMEOUT_CYCLES != 0) &&
                       (r_tcnt == TCNT_W'(TIMEOUT_CYCLES - 1));
  assign w_log_err   = w_pready & r_err;

  always_comb begin
    w_dec = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      w_dec[i] = (int'(w_idx) == i);
    end
  end

  always_comb begin
    w_slv_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_sel[i]) w_slv_rdata |= bus.s_PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    w_next    = r_state;
    w_psel    = '0;
    w_penable = 1'b0;
    unique case (r_state)
      S_IDLE:   if (w_start) w_next = w_mapped ? S_SETUP : S_RESP;
      S_SETUP:  begin
        w_psel = r_sel;
        w_next = S_ACCESS;
      end
      S_ACCESS: begin
        w_psel    = r_sel;
        w_penable = 1'b1;
        if (w_sel_ready || w_timeout) w_next = S_RESP;
      end
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_pwdata <= '0;
      r_sel    <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_tcnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_start) begin
          r_paddr  <= bus.PADDR;
          r_pwrite <= bus.PWRITE;
          r_pwdata <= bus.PWDATA;
          r_sel    <= w_dec;
          r_rdata  <= '0;
          r_err    <= ~w_mapped;
        end
        S_ACCESS: begin
          // Ready takes priority over a timeout expiring in the same cycle.
          if (w_sel_ready) begin
            r_rdata <= r_pwrite ? '0 : w_slv_rdata;
            r_err   <= w_sel_err;
            r_tcnt  <= '0;
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_tcnt  <= '0;
          end else begin
            r_tcnt  <= r_tcnt + TCNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // A clear coinciding with an error clears first, then logs that error.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_err_count <= '0;
      r_last_err  <= '0;
    end else if (err_clr) begin
      r_err_count <= w_log_err ? 16'd1 : 16'd0;
      r_last_err  <= w_log_err ? r_paddr : '0;
    end else if (w_log_err) begin
      if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
      r_last_err <= r_paddr;
    end
  end

  assign bus.PREADY    = w_pready;
  assign bus.PRDATA    = w_pready ? r_rdata : '0;
  assign bus.PSLVERROR = w_pready & r_err;
  assign bus.s_PADDR   = r_paddr;
  assign bus.s_PWRITE  = r_pwrite;
  assign bus.s_PWDATA  = r_pwdata;
  assign bus.s_PSEL    = w_psel;
  assign bus.s_PENABLE = w_penable;
  assign err_count     = r_err_count;
  assign last_err_addr = r_last_err;

endmodule
